// File: rtl/fxp_pkg.sv
// Shared fixed-point types and constants for the FixedPointMaths datapath.
package fxp_pkg;

  localparam int unsigned FXP_WIDTH     = 64;
  localparam int unsigned FXP_FRAC_BITS = 32;

  // Q32.32 saturation limits
  localparam logic [FXP_WIDTH-1:0] FXP_Q_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [FXP_WIDTH-1:0] FXP_Q_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fxp_chunk_sub.sv
// One ripple-borrow slice: sum = a + ~b + cin over W bits.
module fxp_chunk_sub #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  // Subtract by adding the one's complement plus the incoming carry
  always_comb begin
    {cout_c, sum_c} = {1'b0, a} + {1'b0, ~b} + (W + 1)'(cin);
  end

endmodule

// File: rtl/fxp64_serial_subtractor.sv
// Multi-cycle signed fixed-point subtractor: diff = minuend - subtrahend,
// CHUNK_W bits per cycle through a single reused ripple-borrow slice.
module fxp64_serial_subtractor
  import fxp_pkg::*;
#(
  parameter int unsigned WIDTH     = FXP_WIDTH,
  parameter int unsigned FRAC_BITS = FXP_FRAC_BITS,
  parameter int unsigned CHUNK_W   = 16,
  parameter int unsigned SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / CHUNK_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN  = {1'b1, {(WIDTH - 1){1'b0}}};

  // Reject parameter sets the chunked datapath cannot represent
  generate
    if ((WIDTH % CHUNK_W) != 0) begin : g_bad_chunk
      $error("WIDTH must be a multiple of CHUNK_W");
    end
    if (FRAC_BITS >= WIDTH) begin : g_bad_frac
      $error("FRAC_BITS must be smaller than WIDTH");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   raw_q, raw_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   diff_d;
  logic               borrow_d;
  logic               ovf_d;
  logic               out_valid_d;
  logic               in_ready_d;

  logic [CHUNK_W-1:0] chunk_sum;
  logic               chunk_cout;
  logic [WIDTH-1:0]   raw_full;
  logic               ovf_c;

  // Single slice always works on the low chunk of the shifting operands
  fxp_chunk_sub #(
    .W (CHUNK_W)
  ) u_chunk (
    .a      (a_q[CHUNK_W-1:0]),
    .b      (b_q[CHUNK_W-1:0]),
    .cin    (carry_q),
    .sum_c  (chunk_sum),
    .cout_c (chunk_cout)
  );

  // Merge the current slice result into the partial difference
  always_comb begin
    raw_full = raw_q;
    for (int k = 0; k < int'(N); k++) begin
      if (idx_q == IDX_W'(k)) begin
        raw_full[k*CHUNK_W +: CHUNK_W] = chunk_sum;
      end
    end
    ovf_c = (a_msb_q != b_msb_q) && (raw_full[WIDTH-1] != a_msb_q);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    raw_d       = raw_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    diff_d      = diff;
    borrow_d    = borrow_out;
    ovf_d       = overflow;
    out_valid_d = out_valid;
    in_ready_d  = in_ready;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready) begin
          a_d        = minuend;
          b_d        = subtrahend;
          a_msb_d    = minuend[WIDTH-1];
          b_msb_d    = subtrahend[WIDTH-1];
          raw_d      = '0;
          carry_d    = 1'b1;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK_W;
        b_d     = b_q >> CHUNK_W;
        raw_d   = raw_full;
        carry_d = chunk_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          borrow_d    = ~chunk_cout;
          ovf_d       = ovf_c;
          diff_d      = ((SATURATE != 0) && ovf_c) ? (a_msb_q ? NEG_MIN : POS_MAX) : raw_full;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      raw_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      raw_q      <= raw_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      diff       <= diff_d;
      borrow_out <= borrow_d;
      overflow   <= ovf_d;
      out_valid  <= out_valid_d;
      in_ready   <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_fxp64_serial_subtractor.sv
// Scoreboard bench: a wrapping and a saturating instance share stimulus;
// expectations come from plain wide-integer arithmetic.
module tb_fxp64_serial_subtractor;
  import fxp_pkg::*;

  localparam int unsigned LAT = 4;

  typedef struct {
    logic [FXP_WIDTH-1:0] diff;
    logic                 borrow;
    logic                 ovf;
    int                   acc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic [FXP_WIDTH-1:0] minuend = '0;
  logic [FXP_WIDTH-1:0] subtrahend = '0;
  logic [1:0]           in_ready;
  logic [1:0]           out_valid;
  logic [1:0]           borrow_o;
  logic [1:0]           ovf_o;
  logic [FXP_WIDTH-1:0] diff0, diff1;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  bit   ovp0 = 1'b0;
  bit   ovp1 = 1'b0;

  fxp64_serial_subtractor #(.SATURATE(0)) u_dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .minuend(minuend), .subtrahend(subtrahend), .out_valid(out_valid[0]),
    .out_ready(out_ready), .diff(diff0), .borrow_out(borrow_o[0]), .overflow(ovf_o[0])
  );

  fxp64_serial_subtractor #(.SATURATE(1)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .minuend(minuend), .subtrahend(subtrahend), .out_valid(out_valid[1]),
    .out_ready(out_ready), .diff(diff1), .borrow_out(borrow_o[1]), .overflow(ovf_o[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed difference in 65 bits, then classify
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input bit sat, input int acc);
    exp_t r;
    logic signed [64:0] sd, hi, lo;
    sd = $signed({a[63], a}) - $signed({b[63], b});
    hi = {1'b0, FXP_Q_MAX};
    lo = {1'b1, FXP_Q_MIN};
    r.borrow = (a < b);
    r.ovf    = (sd > hi) || (sd < lo);
    r.diff   = (sat && r.ovf) ? (a[63] ? FXP_Q_MIN : FXP_Q_MAX) : (a - b);
    r.acc    = acc;
    return r;
  endfunction

  // Monitor for the wrapping instance
  always @(negedge clk) begin
    if (rst) ovp0 = 1'b0;
    else begin
      if (out_valid[0] && !ovp0) begin
        if (q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_valid_wrap: out_valid high with no pending op");
        end else chk("latency_wrap", 64'(cycle_cnt - q0[0].acc), 64'(LAT));
      end
      if (out_valid[0] && out_ready && q0.size() > 0) begin
        m0 = q0.pop_front();
        chk("diff_wrap", diff0, m0.diff);
        chk("borrow_wrap", 64'(borrow_o[0]), 64'(m0.borrow));
        chk("ovf_wrap", 64'(ovf_o[0]), 64'(m0.ovf));
      end
      ovp0 = out_valid[0];
    end
  end

  // Monitor for the saturating instance
  always @(negedge clk) begin
    if (rst) ovp1 = 1'b0;
    else begin
      if (out_valid[1] && !ovp1) begin
        if (q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_valid_sat: out_valid high with no pending op");
        end else chk("latency_sat", 64'(cycle_cnt - q1[0].acc), 64'(LAT));
      end
      if (out_valid[1] && out_ready && q1.size() > 0) begin
        m1 = q1.pop_front();
        chk("diff_sat", diff1, m1.diff);
        chk("borrow_sat", 64'(borrow_o[1]), 64'(m1.borrow));
        chk("ovf_sat", 64'(ovf_o[1]), 64'(m1.ovf));
      end
      ovp1 = out_valid[1];
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    int k = 0;
    while (!in_ready[0] && k < 40) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready[0]) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_in_ready: in_ready stayed %b", in_ready);
      return;
    end
    minuend = a; subtrahend = b; in_valid = 1'b1;
    @(posedge clk); #1;
    q0.push_back(model(a, b, 1'b0, cycle_cnt));
    q1.push_back(model(a, b, 1'b1, cycle_cnt));
    in_valid = 1'b0;
    minuend = {$urandom, $urandom};
    subtrahend = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output bit ok);
    int k = 0;
    while (!out_valid[0] && k < 40) begin
      @(posedge clk); #1; k++;
    end
    ok = out_valid[0];
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_out_valid: out_valid stayed %b", out_valid);
    end
  endtask

  task automatic finish_op(input int hold);
    bit ok;
    out_ready = 1'b0;
    wait_valid(ok);
    if (!ok) return;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'(2'b00));
    chk("ready_back", 64'(in_ready), 64'(2'b11));
  endtask

  logic [63:0] da [5] = '{64'h0000_0001_8000_0000, 64'h0, 64'h0000_0000_0001_0000,
                          64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0};
  logic [63:0] db [5] = '{64'h0000_0000_4000_0000, 64'h0000_0001_0000_0000, 64'h1,
                          64'h1, 64'h1234_5678_9ABC_DEF0};

  initial begin
    exp_t e0, e1;
    bit ok;
    logic [63:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(2'b00));
    chk("rst_in_ready", 64'(in_ready), 64'(2'b11));
    chk("rst_diff_wrap", diff0, 64'h0);
    chk("rst_diff_sat", diff1, 64'h0);
    chk("rst_borrow", 64'(borrow_o), 64'(2'b00));
    chk("rst_ovf", 64'(ovf_o), 64'(2'b00));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, including a borrow across the chunk boundary and a == b
    for (int i = 0; i < 5; i++) begin
      issue(da[i], db[i]);
      finish_op(0);
    end

    // Long backpressure in DONE on an overflowing subtraction
    a = 64'hC000_0000_0000_0000;
    b = 64'h4000_0000_0000_0001;
    e0 = model(a, b, 1'b0, 0);
    e1 = model(a, b, 1'b1, 0);
    issue(a, b);
    out_ready = 1'b0;
    wait_valid(ok);
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        chk("bp_valid", 64'(out_valid), 64'(2'b11));
        chk("bp_in_ready", 64'(in_ready), 64'(2'b00));
        chk("bp_diff_wrap", diff0, e0.diff);
        chk("bp_diff_sat", diff1, e1.diff);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_valid", 64'(out_valid), 64'(2'b00));
      chk("bp_release_ready", 64'(in_ready), 64'(2'b11));
    end

    // Reset in the middle of RUN abandons the operation
    issue(64'h0000_0005_0000_0000, 64'h0000_0002_0000_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("midrst_valid", 64'(out_valid), 64'(2'b00));
    chk("midrst_diff_wrap", diff0, 64'h0);
    chk("midrst_diff_sat", diff1, 64'h0);
    chk("midrst_borrow", 64'(borrow_o), 64'(2'b00));
    chk("midrst_ovf", 64'(ovf_o), 64'(2'b00));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_in_ready", 64'(in_ready), 64'(2'b11));
    issue(64'h0000_0003_0000_0000, 64'h0000_0000_8000_0000);
    finish_op(1);

    // Randomized operands with boundary-heavy patterns and random backpressure
    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: b = a;
        1: b = a + 64'($urandom_range(0, 3)) - 64'd1;
        2: begin a[63:62] = 2'b10; b[63] = 1'b0; end
        3: begin a[63:62] = 2'b01; b[63] = 1'b1; end
        default: ;
      endcase
      issue(a, b);
      finish_op($urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("pending_wrap", 64'(q0.size()), 64'd0);
    chk("pending_sat", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
